// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised TinyALU with single-cycle logic/arithmetic ops,
// a multi-cycle multiply of configurable latency, busy and illegal-op error flags.
module tinyalu_param #(
    parameter int WIDTH       = 8,
    parameter int MUL_LATENCY = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [2*WIDTH-1:0] result
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(MUL_LATENCY + 1);
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    typedef enum logic {IDLE, MUL} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    result_q, result_d, a_x, b_x, alu;
    logic             done_q, done_d, err_q, err_d;
    assign a_x = RW'(A);
    assign b_x = RW'(B);
    // no_op keeps the previous result; the illegal op falls through to zero
    assign alu = op == OP_ADD ? a_x + b_x :
                 op == OP_SUB ? a_x - b_x :
                 op == OP_AND ? a_x & b_x :
                 op == OP_XOR ? a_x ^ b_x :
                 op == OP_OR  ? a_x | b_x :
                 op == OP_NOP ? result_q  : '0;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (start && op == OP_MUL) begin
                a_d     = A;
                b_d     = B;
                cnt_d   = CW'(MUL_LATENCY - 1);
                state_d = MUL;
            end else if (start) begin
                result_d = alu;
                done_d   = 1'b1;
                err_d    = &op;
            end
        end else if (cnt_q == CW'(1)) begin
            result_d = RW'(a_q) * RW'(b_q);
            done_d   = 1'b1;
            state_d  = IDLE;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
    assign busy   = state_q == MUL;
    assign done   = done_q;
    assign err    = err_q;
    assign result = result_q;
endmodule

// File: tb/tb_tinyalu_param.sv
// tb_tinyalu_param: directed and random stimulus against a timestamp-based reference
// model; expected done responses are queued and checked by an independent monitor.
module tb_tinyalu_param;
    localparam int W = 8;
    localparam int L = 3;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic [2:0]     op = 3'b000;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy, done, err;
    logic [2*W-1:0] result;
    tinyalu_param #(.WIDTH(W), .MUL_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b),
        .busy(busy), .done(done), .err(err), .result(result)
    );
    always #5 clk = ~clk;
    int             n_vec = 0;
    int             n_err = 0;
    logic [2*W:0]   exp_q[$];
    logic [2*W-1:0] last = '0;
    logic           model_busy = 1'b0;
    logic           mul_on = 1'b0;
    logic [2*W-1:0] mul_res = '0;
    int             edge_n = 0;
    int             mul_due = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic logic [2*W-1:0] ref_op(input logic [2:0] o, input int x, input int y);
        case (o)
            3'd0:    return last;
            3'd1:    return (2*W)'(x + y);
            3'd2:    return (2*W)'(x & y);
            3'd3:    return (2*W)'(x ^ y);
            3'd5:    return (2*W)'(x - y);
            3'd6:    return (2*W)'(x | y);
            default: return '0;
        endcase
    endfunction
    // Model of one rising edge: a multiply finishes L-1 edges after the edge that accepted it
    task automatic model_edge();
        logic [2*W-1:0] r;
        edge_n++;
        if (reset) begin
            last   = '0;
            mul_on = 1'b0;
        end else if (mul_on) begin
            if (edge_n == mul_due) begin
                exp_q.push_back({mul_res, 1'b0});
                last   = mul_res;
                mul_on = 1'b0;
            end
        end else if (start) begin
            if (op == 3'd4) begin
                mul_on  = 1'b1;
                mul_due = edge_n + L - 1;
                mul_res = (2*W)'(int'(a) * int'(b));
            end else begin
                r = ref_op(op, int'(a), int'(b));
                exp_q.push_back({r, op == 3'd7});
                last = r;
            end
        end
        model_busy = mul_on;
    endtask
    task automatic step(input logic r, input logic s, input logic [2:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        reset = r;
        start = s;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        model_edge();
        #1;
    endtask
    always @(negedge clk) begin
        logic [2*W:0] e;
        chk("busy", 32'(busy), 32'(model_busy));
        chk("result_hold", 32'(result), 32'(last));
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_result", 32'(result), 32'(e[2*W:1]));
                chk("done_err", 32'(err), 32'(e[0]));
                chk("busy_with_done", 32'(busy), 32'(0));
            end
        end else begin
            chk("err_without_done", 32'(err), 32'(0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("missing_done", 32'(done), 32'(1));
            end
        end
    end
    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 8'h11, 8'h22);
        step(0, 1, 1, 8'hFF, 8'h01);
        step(0, 0, 0, 0, 0);
        step(0, 1, 4, 8'hFF, 8'hFF);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 1, 5, 8'h01, 8'h02);
        step(0, 1, 6, 8'hF0, 8'h0F);
        step(0, 0, 0, 0, 0);
        step(0, 1, 4, 8'h02, 8'h03);
        step(0, 1, 1, 8'h01, 8'h01);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 7, 8'h12, 8'h34);
        step(0, 1, 0, 8'h55, 8'h66);
        step(0, 0, 0, 0, 0);
        step(0, 1, 4, 8'h10, 8'h10);
        step(0, 0, 0, 8'hAA, 8'hBB);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 8'h01, 8'h01);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 1500; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        repeat (L + 2) step(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
